// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer for a 2-input bitwise gate: walks every {a,b} vector, samples the gate
// output after a fixed settle time and tallies mismatches against a reference function.
module gate_sweep_ctrl #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic             fail_valid_o,
    output logic [WIDTH-1:0] first_fail_a_o,
    output logic [WIDTH-1:0] first_fail_b_o
);

    localparam int unsigned VecW = 2 * WIDTH;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [VecW-1:0]   vec_q, vec_d;
    logic [CntW-1:0]   settle_q, settle_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0]  ff_a_q, ff_a_d;
    logic [WIDTH-1:0]  ff_b_q, ff_b_d;

    logic [WIDTH-1:0]  cur_a, cur_b, exp_c;
    logic              sample, last_vec, mismatch;

    assign cur_a    = vec_q[VecW-1:WIDTH];
    assign cur_b    = vec_q[WIDTH-1:0];
    assign sample   = (state_q == StRun) && (settle_q == '0);
    assign last_vec = &vec_q;

    always_comb begin
        unique case (op_q)
            3'd0:    exp_c = cur_a & cur_b;
            3'd1:    exp_c = cur_a | cur_b;
            3'd2:    exp_c = cur_a ^ cur_b;
            3'd3:    exp_c = ~(cur_a & cur_b);
            3'd4:    exp_c = ~(cur_a | cur_b);
            3'd5:    exp_c = ~(cur_a ^ cur_b);
            3'd6:    exp_c = ~cur_a;
            default: exp_c = cur_a;
        endcase
    end

    assign mismatch = (c_i != exp_c);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (sample && last_vec) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_d         = op_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        ff_a_d       = ff_a_q;
        ff_b_d       = ff_b_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d         = op_i;
                    vec_d        = '0;
                    settle_d     = SettleLoad;
                    busy_d       = 1'b1;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            StRun: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CntW'(1);
                end else begin
                    if (mismatch) begin
                        if (!(&err_q)) err_d = err_q + ERR_W'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            ff_a_d       = cur_a;
                            ff_b_d       = cur_b;
                        end
                    end
                    if (last_vec) begin
                        // Park operands at zero so the gate idles on a known vector.
                        vec_d  = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_d == '0);
                    end else begin
                        vec_d    = vec_q + VecW'(1);
                        settle_d = SettleLoad;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q         <= '0;
            vec_q        <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            ff_a_q       <= '0;
            ff_b_q       <= '0;
        end else begin
            op_q         <= op_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            ff_a_q       <= ff_a_d;
            ff_b_q       <= ff_b_d;
        end
    end

    assign a_o            = cur_a;
    assign b_o            = cur_b;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign err_count_o    = err_q;
    assign fail_valid_o   = fail_valid_q;
    assign first_fail_a_o = ff_a_q;
    assign first_fail_b_o = ff_b_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (narrow/slow and wide/fast/saturating) driven by
// directed and random sweeps, checked against a per-vector reference tally.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start1, start2;
    logic [2:0] op1, op2;
    logic [0:0] a1, b1, c1, ffa1, ffb1;
    logic [1:0] a2, b2, c2, ffa2, ffb2;
    logic       busy1, done1, pass1, fv1;
    logic       busy2, done2, pass2, fv2;
    logic [7:0] err1;
    logic [1:0] err2;

    // Gate-under-test model: a chosen function, optional stuck-at-0, per-vector bit flips.
    logic [2:0] gfn;
    logic       stuck;
    logic [1:0] flip [16];
    logic [1:0] g1, g2;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [1:0] gate_fn(input logic [2:0] f, input logic [1:0] x,
                                           input logic [1:0] y);
        case (f)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    assign g1 = gate_fn(gfn, {1'b0, a1}, {1'b0, b1}) ^ flip[{a1, b1}];
    assign g2 = gate_fn(gfn, a2, b2) ^ flip[{a2, b2}];
    assign c1 = stuck ? 1'b0 : g1[0];
    assign c2 = stuck ? 2'b00 : g2;

    gate_sweep_ctrl #(.WIDTH(1), .SETTLE(2), .ERR_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .op_i(op1), .a_o(a1), .b_o(b1),
        .c_i(c1), .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .fail_valid_o(fv1), .first_fail_a_o(ffa1), .first_fail_b_o(ffb1)
    );

    gate_sweep_ctrl #(.WIDTH(2), .SETTLE(1), .ERR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .op_i(op2), .a_o(a2), .b_o(b2),
        .c_i(c2), .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .fail_valid_o(fv2), .first_fail_a_o(ffa2), .first_fail_b_o(ffb2)
    );

    // Observation mux so one sweep task serves both instances.
    logic       sel;
    logic [3:0] o_ab;
    logic [1:0] o_ffa, o_ffb;
    logic [7:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;

    always_comb begin
        if (sel) begin
            o_ab = {a2, b2}; o_ffa = ffa2; o_ffb = ffb2; o_err = {6'b0, err2};
            o_busy = busy2; o_done = done2; o_pass = pass2; o_fv = fv2;
        end else begin
            o_ab = {2'b0, a1, b1}; o_ffa = {1'b0, ffa1}; o_ffb = {1'b0, ffb1};
            o_err = err1; o_busy = busy1; o_done = done1; o_pass = pass1; o_fv = fv1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_start(input bit which, input logic v, input logic [2:0] op);
        if (which) begin
            start2 = v; op2 = op;
        end else begin
            start1 = v; op1 = op;
        end
    endtask

    task automatic run_sweep(input bit which, input logic [2:0] op, input int restart_at,
                             input bit start_in_done);
        int unsigned w    = which ? 2 : 1;
        int unsigned s    = which ? 1 : 2;
        int unsigned n    = 1 << (2 * w);
        int unsigned emax = which ? 3 : 255;
        logic [1:0]  wm   = which ? 2'b11 : 2'b01;
        int unsigned e_err = 0;
        bit          e_fv  = 1'b0;
        int unsigned e_fa  = 0, e_fb = 0;
        logic [1:0]  av, bv, got, expv;

        for (int k = 0; k < int'(n); k++) begin
            av   = 2'(k >> w);
            bv   = 2'(k) & wm;
            got  = stuck ? 2'b00 : ((gate_fn(gfn, av, bv) ^ flip[k]) & wm);
            expv = gate_fn(op, av, bv) & wm;
            if (got != expv) begin
                if (e_err < emax) e_err++;
                if (!e_fv) begin
                    e_fv = 1'b1; e_fa = av; e_fb = bv;
                end
            end
        end

        sel = which;
        @(posedge clk); #1;
        drive_start(which, 1'b1, op);
        @(posedge clk); #1;
        drive_start(which, 1'b0, 3'($urandom));
        check_val("start_busy", o_busy, 1);
        check_val("start_ab", o_ab, 0);
        check_val("start_err", o_err, 0);
        check_val("start_fv", o_fv, 0);
        check_val("start_pass", o_pass, 0);

        for (int t = 1; t <= int'(n * s); t++) begin
            if (t == restart_at) drive_start(which, 1'b1, 3'd0);
            @(posedge clk); #1;
            drive_start(which, 1'b0, 3'($urandom));
            if (t < int'(n * s)) begin
                check_val("run_ab", o_ab, t / s);
                check_val("run_busy", o_busy, 1);
                check_val("run_done", o_done, 0);
            end else begin
                check_val("end_done", o_done, 1);
                check_val("end_busy", o_busy, 0);
                check_val("end_ab", o_ab, 0);
                check_val("end_pass", o_pass, (e_err == 0));
                check_val("end_err", o_err, e_err);
                check_val("end_fv", o_fv, e_fv);
                if (e_fv) begin
                    check_val("end_ffa", o_ffa, e_fa);
                    check_val("end_ffb", o_ffb, e_fb);
                end
            end
        end

        if (start_in_done) drive_start(which, 1'b1, op);
        @(posedge clk); #1;
        drive_start(which, 1'b0, op);
        check_val("post_done", o_done, 0);
        check_val("post_busy", o_busy, 0);
        check_val("hold_err", o_err, e_err);
        check_val("hold_pass", o_pass, (e_err == 0));
        check_val("hold_fv", o_fv, e_fv);
        @(posedge clk); #1;
        check_val("idle_busy", o_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; start2 = 1'b0; op1 = 3'd0; op2 = 3'd0;
        gfn = 3'd2; stuck = 1'b0; sel = 1'b0;
        for (int k = 0; k < 16; k++) flip[k] = 2'b00;

        #1;
        check_val("rst_busy1", busy1, 0);
        check_val("rst_ab1", {a1, b1}, 0);
        check_val("rst_err1", err1, 0);
        check_val("rst_misc1", {done1, pass1, fv1, ffa1, ffb1}, 0);
        check_val("rst_busy2", busy2, 0);
        check_val("rst_err2", err2, 0);
        check_val("rst_misc2", {a2, b2, done2, pass2, fv2, ffa2, ffb2}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Correct XOR, stuck-at-0, NAND reference, restart mid-sweep plus start during DONE.
        run_sweep(1'b0, 3'd2, 0, 1'b0);
        stuck = 1'b1;
        run_sweep(1'b0, 3'd2, 0, 1'b0);
        stuck = 1'b0;
        run_sweep(1'b0, 3'd3, 0, 1'b0);
        run_sweep(1'b0, 3'd2, 3, 1'b1);

        // Reset between edges 3 and 4 of a NAND-vs-XOR sweep that already logged a failure.
        sel = 1'b0;
        @(posedge clk); #1;
        drive_start(1'b0, 1'b1, 3'd3);
        @(posedge clk); #1;
        drive_start(1'b0, 1'b0, 3'd3);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check_val("pre_rst_err", o_err, 1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_ab", o_ab, 0);
        check_val("mid_rst_busy", o_busy, 0);
        check_val("mid_rst_err", o_err, 0);
        check_val("mid_rst_fv", o_fv, 0);
        #1 rst = 1'b0;
        run_sweep(1'b0, 3'd2, 0, 1'b0);

        // Wide instance: every vector inverted so the 2-bit counter saturates.
        for (int k = 0; k < 16; k++) flip[k] = 2'b11;
        run_sweep(1'b1, 3'd2, 0, 1'b0);
        for (int k = 0; k < 16; k++) flip[k] = 2'b00;
        run_sweep(1'b1, 3'd2, 0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            bit which = it[0];
            int span  = which ? 16 : 8;
            gfn   = 3'($urandom);
            stuck = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 16; k++)
                flip[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            run_sweep(which, 3'($urandom),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, span - 1) : 0,
                      1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
